twohot_seq_checker: RTL
=======================

Name: twohot_seq_checker

Overview:
- Consumer-side checker for the two-bit-set sequence generator: accepts a stream of N-bit words, decodes each into (hi, lo) bit indices, and checks it against the canonical sweep order.
- Canonical order: (1,0),(2,0),(2,1),(3,0),(3,1),(3,2),…,(N-1,N-2), then wrap to (1,0); N*(N-1)/2 words per sweep.
- Sits at the sink of the generator in self-checking benches and BIST paths; reports decoded indices, errors, and sweep completion.

Parameters:
- N, 4, word width; legal range 3..32.
- IDXW, $clog2(N), index width (derived; do not override).
- CNTW, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  level; 0 forces IDLE at the next edge
- in_valid  in  1  input word valid
- in_data  in  N  candidate two-hot word
- in_ready  out  1  checker can accept a word
- dec_valid  out  1  decoded result valid
- dec_ready  in  1  downstream accepts result
- dec_hi  out  IDXW  index of upper set bit
- dec_lo  out  IDXW  index of lower set bit
- dec_err  out  2  per-result error: 0 ok, 1 not two-hot, 2 out of order
- sweep_done  out  1  one-cycle pulse when (N-1,N-2) is accepted in order
- locked  out  1  FSM in LOCK
- err_count  out  CNTW  saturating count of erroneous words

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; expected=(1,0); every output 0; err_count=0.
- Handshake: an input transfer occurs when in_valid && in_ready. in_ready = en && (!dec_valid || dec_ready) in SYNC/LOCK, and 0 in IDLE. Single output register; result appears one cycle after the input transfer. The result holds until dec_ready is high while dec_valid=1. A new transfer in the same cycle replaces the result, giving full throughput.
- Decode: popcount(in_data)!=2 sets dec_err=1, dec_hi=dec_lo=0. Otherwise dec_hi is the MSB set index and dec_lo is the LSB set index.
- FSM:
  - IDLE: if en, go to SYNC next cycle.
  - SYNC: accepted words produce results. Only a two-hot (1,0) locks the checker: go to LOCK and set expected=(2,0). All other words in SYNC report dec_err=1 or 2 and do not count in err_count.
  - LOCK: compare each accepted word with expected.
    - Match: dec_err=0; advance expected. If lo<hi-1, lo+1; else if hi<N-1, hi+1 and lo=0; else wrap to (1,0) and pulse sweep_done in the same cycle dec_valid rises.
    - Mismatch: dec_err=1 or 2, err_count+1 (saturate at all-ones), expected still advances.
  - Any state with en=0: go to IDLE. Drop a pending result (dec_valid=0). Keep err_count.
- Priority: rst > en=0 > transfer. rst mid-sweep clears everything, and the next sweep must re-lock.
- Bits of in_data at or above N do not exist. No X-propagation: outputs are driven registers only.

Optional Feature:
- Macro TWOHOT_RESYNC_EN.
  - Defined: on an out-of-order (err=2) word in LOCK, expected is reloaded to the successor of the received (hi,lo), so a single drop costs one error. Not-two-hot errors still advance normally.
  - Undefined: expected always advances by one per accepted word, as described above.

Decomposition:
- Package twohot_pkg:
  - state_t enum {IDLE,SYNC,LOCK}
  - err_t enum {ERR_NONE=0,ERR_NOT2HOT=1,ERR_ORDER=2}
  - function next_pair(hi,lo,N) returning the successor pair.
- Sub-module twohot_decode: combinational popcount==2 flag plus MSB/LSB priority encoders. Instanced once.

Test Plan:
- N=4, en=1, full-rate generator stream 0011,0101,0110,1001,1010,1100,0011: locked after the first word; all dec_err=0; (hi,lo) = (1,0),(2,0),(2,1),(3,0),(3,1),(3,2),(1,0); sweep_done pulses exactly once, with (3,2); err_count=0.
- Backpressure: hold dec_ready=0 for 3 cycles after the first result: in_ready=0 during the stall, dec_hi/dec_lo held stable, no word lost, same sequence afterwards.
- Bad words in LOCK: inject 0111 then 0000 after lock → dec_err=1 for both, err_count=2, with expected advancing twice.
- Order error (N=4), stream 0011,0110: second result is dec_err=2, err_count=1. Without the macro, the next word 1001 is also an error; with TWOHOT_RESYNC_EN, 1001 is ok.
- Pre-lock junk, stream 0101,1100,0011: the first two words report err=2, err_count=0, locked rises only after 0011.
- rst asserted mid-sweep after 3 words → next cycle all outputs 0 and state IDLE. Deassert, then stream 0101: no lock. Then 0011: checker locks.

Source files
------------

// File: rtl/twohot_pkg.sv
// rtl/twohot_pkg.sv - shared types and sweep-order helper for the two-hot sequence checker
//
// Contents:
//   state_t   : checker FSM states (IDLE, SYNC, LOCK)
//   err_t     : per-result error code (0 ok, 1 not two-hot, 2 out of order)
//   pair_t    : (hi, lo) index pair, wide enough for the largest legal word (32 bits)
//   next_pair : successor of (hi, lo) in the canonical sweep for an n-bit word
package twohot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NOT2HOT = 2'd1,
    ERR_ORDER   = 2'd2
  } err_t;

  localparam int PAIR_W = 5;

  typedef struct packed {
    logic [PAIR_W-1:0] hi;
    logic [PAIR_W-1:0] lo;
  } pair_t;

  // Sweep order: lo walks 0..hi-1 under each hi, hi walks 1..n-1, then wraps to (1,0).
  function automatic pair_t next_pair(input logic [PAIR_W-1:0] hi,
                                      input logic [PAIR_W-1:0] lo,
                                      input int                n);
    pair_t p;
    if (({1'b0, lo} + 6'd1) < {1'b0, hi}) begin
      p.hi = hi;
      p.lo = lo + PAIR_W'(1);
    end else if (int'({27'd0, hi}) < (n - 1)) begin
      p.hi = hi + PAIR_W'(1);
      p.lo = '0;
    end else begin
      p.hi = PAIR_W'(1);
      p.lo = '0;
    end
    return p;
  endfunction

endpackage

// File: rtl/twohot_decode.sv
// rtl/twohot_decode.sv - combinational two-hot detector with MSB/LSB index encoders
//
// Ports:
//   data    in  N     candidate word
//   two_hot out 1     exactly two bits of data are set
//   hi      out IDXW  index of the highest set bit (0 unless two_hot)
//   lo      out IDXW  index of the lowest set bit (0 unless two_hot)
module twohot_decode #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    data,
  output logic            two_hot,
  output logic [IDXW-1:0] hi,
  output logic [IDXW-1:0] lo
);

  logic [5:0]      ones;
  logic [IDXW-1:0] msb;
  logic [IDXW-1:0] lsb;

  always_comb begin
    ones = '0;
    msb  = '0;
    lsb  = '0;
    // Ascending scan leaves the highest set index in msb; descending scan leaves the lowest in lsb.
    for (int i = 0; i < N; i++) begin
      if (data[i]) begin
        ones = ones + 6'd1;
        msb  = IDXW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (data[i]) begin
        lsb = IDXW'(i);
      end
    end
    two_hot = (ones == 6'd2);
    hi      = two_hot ? msb : '0;
    lo      = two_hot ? lsb : '0;
  end

endmodule

// File: rtl/twohot_seq_checker.sv
// rtl/twohot_seq_checker.sv - sink-side checker for the canonical two-hot sweep sequence
//
// Optional build macro: TWOHOT_RESYNC_EN (an out-of-order word in LOCK reloads the expected
// pair to the successor of the received pair instead of advancing by one).
//
// Ports:
//   clk        in  1     clock
//   rst        in  1     synchronous active-high reset
//   en         in  1     level enable; 0 returns the checker to IDLE and drops a pending result
//   in_valid   in  1     input word valid
//   in_data    in  N     candidate two-hot word
//   in_ready   out 1     checker can accept a word
//   dec_valid  out 1     decoded result valid
//   dec_ready  in  1     downstream accepts result
//   dec_hi     out IDXW  index of upper set bit
//   dec_lo     out IDXW  index of lower set bit
//   dec_err    out 2     0 ok, 1 not two-hot, 2 out of order
//   sweep_done out 1     one-cycle pulse when the last pair of a sweep is accepted in order
//   locked     out 1     checker is in LOCK
//   err_count  out CNTW  saturating count of erroneous words seen in LOCK
module twohot_seq_checker
  import twohot_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  input  logic [N-1:0]    in_data,
  output logic            in_ready,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [IDXW-1:0] dec_hi,
  output logic [IDXW-1:0] dec_lo,
  output logic [1:0]      dec_err,
  output logic            sweep_done,
  output logic            locked,
  output logic [CNTW-1:0] err_count
);

  state_t            state;
  state_t            state_nxt;
  logic [PAIR_W-1:0] exp_hi;
  logic [PAIR_W-1:0] exp_lo;
  logic [PAIR_W-1:0] exp_hi_nxt;
  logic [PAIR_W-1:0] exp_lo_nxt;
  logic              two_hot;
  logic [IDXW-1:0]   w_hi;
  logic [IDXW-1:0]   w_lo;
  logic              xfer;
  logic              match;
  logic              sync_hit;
  logic              at_last;
  logic              count_err;
  logic              sweep_nxt;
  err_t              err_nxt;
  pair_t             np_exp;

  twohot_decode #(
    .N    (N),
    .IDXW (IDXW)
  ) u_decode (
    .data    (in_data),
    .two_hot (two_hot),
    .hi      (w_hi),
    .lo      (w_lo)
  );

  // Single output register: a new word may enter whenever the held result is leaving.
  assign in_ready = en && (state != IDLE) && (!dec_valid || dec_ready);
  assign xfer     = in_valid && in_ready;
  assign locked   = (state == LOCK);

  assign match    = two_hot && (PAIR_W'(w_hi) == exp_hi) && (PAIR_W'(w_lo) == exp_lo);
  assign sync_hit = two_hot && (w_hi == IDXW'(1)) && (w_lo == '0);
  assign at_last  = (exp_hi == PAIR_W'(N - 1)) && (exp_lo == PAIR_W'(N - 2));
  assign np_exp   = next_pair(exp_hi, exp_lo, N);

`ifdef TWOHOT_RESYNC_EN
  pair_t np_rx;
  assign np_rx = next_pair(PAIR_W'(w_hi), PAIR_W'(w_lo), N);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    exp_hi_nxt = exp_hi;
    exp_lo_nxt = exp_lo;
    count_err  = 1'b0;
    sweep_nxt  = 1'b0;
    err_nxt    = ERR_NONE;

    // In SYNC only (1,0) is acceptable; in LOCK the word must equal the expected pair.
    if (!two_hot) begin
      err_nxt = ERR_NOT2HOT;
    end else if ((state == SYNC) ? !sync_hit : !match) begin
      err_nxt = ERR_ORDER;
    end

    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = SYNC;
        SYNC: begin
          if (xfer && sync_hit) begin
            state_nxt  = LOCK;
            exp_hi_nxt = PAIR_W'(2);
            exp_lo_nxt = '0;
          end
        end
        LOCK: begin
          if (xfer) begin
            if (match) begin
              sweep_nxt = at_last;
            end else begin
              count_err = 1'b1;
            end
            exp_hi_nxt = np_exp.hi;
            exp_lo_nxt = np_exp.lo;
`ifdef TWOHOT_RESYNC_EN
            if (two_hot && !match) begin
              exp_hi_nxt = np_rx.hi;
              exp_lo_nxt = np_rx.lo;
            end
`endif
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_hi     <= PAIR_W'(1);
      exp_lo     <= '0;
      dec_valid  <= 1'b0;
      dec_hi     <= '0;
      dec_lo     <= '0;
      dec_err    <= '0;
      sweep_done <= 1'b0;
      err_count  <= '0;
    end else if (!en) begin
      dec_valid  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      exp_hi     <= exp_hi_nxt;
      exp_lo     <= exp_lo_nxt;
      sweep_done <= xfer && sweep_nxt;
      if (xfer) begin
        dec_valid <= 1'b1;
        dec_hi    <= w_hi;
        dec_lo    <= w_lo;
        dec_err   <= err_nxt;
        if (count_err && (err_count != '1)) begin
          err_count <= err_count + CNTW'(1);
        end
      end else if (dec_ready) begin
        dec_valid <= 1'b0;
      end
    end
  end

endmodule
